branch_resolve_tx: RTL and testbench

BRANCH_RESOLVE_TX -- requirements
Module: branch_resolve_tx

---
 rtl/branch_resolve_tx.sv | 148 ++++++++++++++
 tb/tb_branch_resolve_tx.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_tx.sv
// ---------------------------------------------------------------------------
// branch_resolve_tx
//
// Collects resolved conditional branches from the execute stage into a window
// of up to seven and reports them to the branch-prediction front end as one
// 42-bit packet. A mispredict closes the window immediately with a correction
// packet. Otherwise the window closes with a commit packet when it fills or
// when it has sat idle for IDLE_LIMIT cycles. At most one packet is
// outstanding: the block stops accepting resolves until the front end frees
// that packet.
//
// Packet layout (o_data_42):
//   [41]    mispredict flag
//   [40:38] branches retired by this packet (1..7)
//   [37:35] window index of the mispredicted branch (0 for commits)
//   [34:32] zero
//   [31:0]  correct next PC (0 for commits)
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous reset, active low
//   i_resValid   resolved branch offered by the execute stage
//   i_resTaken   actual direction
//   i_predTaken  predicted direction
//   i_resPc_32   correct next PC of the resolved branch
//   o_resReady   resolve accepted when i_resValid and o_resReady are both high
//   o_drive      one-cycle pulse marking a new packet on o_data_42
//   o_data_42    registered packet, stable until freed
//   i_free       one-cycle pulse: front end consumed the packet
// ---------------------------------------------------------------------------
module branch_resolve_tx #(
    parameter int IDLE_LIMIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_resValid,
    input  logic        i_resTaken,
    input  logic        i_predTaken,
    input  logic [31:0] i_resPc_32,
    output logic        o_resReady,
    output logic        o_drive,
    output logic [41:0] o_data_42,
    input  logic        i_free
);

    // Wide enough to hold IDLE_LIMIT without wrapping.
    localparam int IW = (IDLE_LIMIT < 2) ? 1 : $clog2(IDLE_LIMIT + 1);
    // The timeout fires on the idle cycle that would bring the count to
    // IDLE_LIMIT, so the packet is driven the cycle after that idle cycle.
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_LIMIT - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        SEND  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [IW-1:0]   idle_q, idle_d;
    logic            drive_q, drive_d;
    logic            ready_q, ready_d;
    logic [41:0]     data_q, data_d;

    logic [2:0]      cnt_inc;
    logic            mispredict;

    assign cnt_inc    = cnt_q + 3'd1;
    assign mispredict = i_resTaken != i_predTaken;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idle_d  = idle_q;
        data_d  = data_q;
        drive_d = 1'b0;

        unique case (state_q)
            ACCUM: begin
                if (i_resValid) begin
                    // An accept always clears the idle run, even on the
                    // cycle the timeout would otherwise fire.
                    idle_d = '0;
                    if (mispredict) begin
                        data_d  = {1'b1, cnt_inc, cnt_q, 3'b000, i_resPc_32};
                        cnt_d   = 3'd0;
                        state_d = SEND;
                        drive_d = 1'b1;
                    end else if (cnt_q == 3'd6) begin
                        data_d  = {1'b0, 3'd7, 3'd0, 3'b000, 32'd0};
                        cnt_d   = 3'd0;
                        state_d = SEND;
                        drive_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else if (cnt_q == 3'd0) begin
                    idle_d = '0;
                end else if (idle_q == IDLE_LAST) begin
                    data_d  = {1'b0, cnt_q, 3'd0, 3'b000, 32'd0};
                    cnt_d   = 3'd0;
                    idle_d  = '0;
                    state_d = SEND;
                    drive_d = 1'b1;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end

            SEND: begin
                // i_free may arrive with the drive pulse itself.
                if (i_free) begin
                    state_d = ACCUM;
                end
            end

            default: begin
                state_d = ACCUM;
            end
        endcase

        // Ready tracks the state it will describe, so it rises the same
        // cycle the block is back in ACCUM.
        ready_d = (state_d == ACCUM);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ACCUM;
            cnt_q   <= 3'd0;
            idle_q  <= '0;
            drive_q <= 1'b0;
            ready_q <= 1'b1;
            data_q  <= 42'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idle_q  <= idle_d;
            drive_q <= drive_d;
            ready_q <= ready_d;
            data_q  <= data_d;
        end
    end

    assign o_resReady = ready_q;
    assign o_drive    = drive_q;
    assign o_data_42  = data_q;

endmodule

// File: tb/tb_branch_resolve_tx.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_tx
//
// Directed scenarios followed by random traffic against a transaction-level
// model. The driver predicts each packet and queues it; an independent
// monitor pops and compares whenever o_drive is seen.
// ---------------------------------------------------------------------------
module tb_branch_resolve_tx;

    localparam int IDLE_LIMIT = 15;

    logic        clk;
    logic        rst;
    logic        i_resValid;
    logic        i_resTaken;
    logic        i_predTaken;
    logic [31:0] i_resPc_32;
    logic        o_resReady;
    logic        o_drive;
    logic [41:0] o_data_42;
    logic        i_free;

    int vec_cnt;
    int err_cnt;

    logic [41:0] exp_q[$];

    // Model: the window is just a count of correct branches seen so far,
    // plus the length of the current run of idle cycles.
    bit m_busy;
    int m_pend;
    int m_idle;

    branch_resolve_tx #(.IDLE_LIMIT(IDLE_LIMIT)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_resValid  (i_resValid),
        .i_resTaken  (i_resTaken),
        .i_predTaken (i_predTaken),
        .i_resPc_32  (i_resPc_32),
        .o_resReady  (o_resReady),
        .o_drive     (o_drive),
        .o_data_42   (o_data_42),
        .i_free      (i_free)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [41:0] mk(input bit fl, input int c, input int e,
                                       input logic [31:0] pc);
        logic [2:0] c3;
        logic [2:0] e3;
        c3 = 3'(c);
        e3 = 3'(e);
        return {fl, c3, e3, 3'b000, pc};
    endfunction

    // One clock cycle: check ready against the model, drive inputs, then
    // advance the model to what the coming edge should do.
    task automatic cyc(input logic v, input logic t, input logic p,
                       input logic [31:0] pc, input logic f);
        @(negedge clk);
        vec_cnt++;
        if (o_resReady !== !m_busy) begin
            err_cnt++;
            $display("FAIL ready @%0t: got %b want %b", $time, o_resReady, !m_busy);
        end
        i_resValid  = v;
        i_resTaken  = t;
        i_predTaken = p;
        i_resPc_32  = pc;
        i_free      = f;
        if (!m_busy) begin
            if (v) begin
                m_idle = 0;
                if (t != p) begin
                    exp_q.push_back(mk(1'b1, m_pend + 1, m_pend, pc));
                    m_pend = 0;
                    m_busy = 1'b1;
                end else if (m_pend == 6) begin
                    exp_q.push_back(mk(1'b0, 7, 0, 32'd0));
                    m_pend = 0;
                    m_busy = 1'b1;
                end else begin
                    m_pend++;
                end
            end else if (m_pend == 0) begin
                m_idle = 0;
            end else begin
                m_idle++;
                if (m_idle == IDLE_LIMIT) begin
                    exp_q.push_back(mk(1'b0, m_pend, 0, 32'd0));
                    m_pend = 0;
                    m_idle = 0;
                    m_busy = 1'b1;
                end
            end
        end else if (f) begin
            m_busy = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic free1();
        cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_resValid  = 1'b0;
        i_resTaken  = 1'b0;
        i_predTaken = 1'b0;
        i_resPc_32  = 32'd0;
        i_free      = 1'b0;
        rst = 1'b0;
        #1;
        vec_cnt += 3;
        if (o_drive !== 1'b0) begin
            err_cnt++; $display("FAIL rst_drive: got %b want 0", o_drive);
        end
        if (o_data_42 !== 42'd0) begin
            err_cnt++; $display("FAIL rst_data: got %h want 0", o_data_42);
        end
        if (o_resReady !== 1'b1) begin
            err_cnt++; $display("FAIL rst_ready: got %b want 1", o_resReady);
        end
        m_busy = 1'b0;
        m_pend = 0;
        m_idle = 0;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Monitor: every drive pulse must match the oldest expected packet, and
    // an expected packet must show up on the very edge the model predicts.
    logic [41:0] last_pkt;
    initial last_pkt = 42'd0;

    always @(posedge clk) begin
        #1;
        if (rst) begin
            if (o_drive) begin
                vec_cnt++;
                if (exp_q.size() == 0) begin
                    err_cnt++;
                    $display("FAIL spurious_drive: got %h want no packet", o_data_42);
                end else begin
                    logic [41:0] e;
                    e = exp_q.pop_front();
                    if (o_data_42 !== e) begin
                        err_cnt++;
                        $display("FAIL packet: got %h want %h", o_data_42, e);
                    end
                end
                if (o_resReady !== 1'b0) begin
                    err_cnt++;
                    $display("FAIL drive_ready: got %b want 0", o_resReady);
                end
                last_pkt = o_data_42;
            end else begin
                if (exp_q.size() != 0) begin
                    vec_cnt++;
                    err_cnt++;
                    $display("FAIL missing_drive: got no pulse want %h", exp_q[0]);
                    void'(exp_q.pop_front());
                end
                if (!o_resReady) begin
                    vec_cnt++;
                    if (o_data_42 !== last_pkt) begin
                        err_cnt++;
                        $display("FAIL hold: got %h want %h", o_data_42, last_pkt);
                    end
                end
            end
        end
    end

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        m_busy  = 1'b0;
        m_pend  = 0;
        m_idle  = 0;
        rst = 1'b0;
        i_resValid = 1'b0; i_resTaken = 1'b0; i_predTaken = 1'b0;
        i_resPc_32 = 32'd0; i_free = 1'b0;

        do_reset();

        // Six correct, then mispredict at 0x1040: counter 7, errPos 6.
        for (int k = 0; k < 6; k++) cyc(1'b1, 1'b1, 1'b1, $urandom, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 32'h0000_1040, 1'b0);
        idle(2);
        free1();
        idle(2);

        // Seven correct: full-window commit, ready low until freed.
        for (int k = 0; k < 7; k++) cyc(1'b1, 1'b0, 1'b0, $urandom, 1'b0);
        idle(3);
        free1();

        // Two correct then a timeout commit of 2.
        cyc(1'b1, 1'b1, 1'b1, 32'd0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        idle(IDLE_LIMIT + 2);
        free1();

        // Resolve held through SEND, free after 5 cycles, then accepted.
        cyc(1'b1, 1'b1, 1'b0, 32'hDEAD_BEE0, 1'b0);
        for (int k = 0; k < 5; k++) cyc(1'b1, 1'b1, 1'b1, 32'h1234_5678, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 32'h1234_5678, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 32'h1234_5678, 1'b0);
        idle(2);

        // Timeout fires on the same cycle an accept arrives: accept wins.
        do_reset();
        cyc(1'b1, 1'b1, 1'b1, 32'd0, 1'b0);
        idle(IDLE_LIMIT - 1);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        idle(IDLE_LIMIT + 2);
        free1();

        // Reset while a mispredict packet is outstanding; late free ignored.
        cyc(1'b1, 1'b0, 1'b1, 32'hCAFE_0004, 1'b0);
        idle(2);
        do_reset();
        free1();
        idle(2);

        // Mispredict first after reset, freed on the drive cycle.
        do_reset();
        cyc(1'b1, 1'b1, 1'b0, 32'h0000_2000, 1'b0);
        free1();
        idle(2);

        // Random traffic: busy phase, then sparse phase to reach timeouts.
        for (int ph = 0; ph < 2; ph++) begin
            for (int k = 0; k < 2000; k++) begin
                logic v, t, p, f;
                v = (ph == 0) ? ($urandom_range(99) < 60) : ($urandom_range(99) < 6);
                t = $urandom_range(1);
                p = t ^ ($urandom_range(4) == 0);
                f = m_busy ? ($urandom_range(99) < 35) : ($urandom_range(99) < 5);
                if ($urandom_range(999) < 3) do_reset();
                else cyc(v, t, p, $urandom, f);
            end
        end

        // Drain any outstanding packet.
        idle(2);
        free1();
        idle(3);

        vec_cnt++;
        if (exp_q.size() != 0) begin
            err_cnt++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
